// File: rtl/axi_manager_bridge_if.sv
// -----------------------------------------------------------------------------
// axi_manager_bridge_if
// Single-beat AXI4 bus bundle between the cpuif-to-AXI manager bridge and the
// fabric.
//   master : AW/W/AR payload and valids, B/R readies (driven by the bridge)
//   slave  : AW/W/AR readies, B/R responses (driven by the fabric)
// Parameters: AddrWidth (address), UserWidth (AxUSER/xUSER), IdWidth (AxID/xID).
// Data width is fixed at 32 bits with 4 byte strobes.
// -----------------------------------------------------------------------------
interface axi_manager_bridge_if #(
    parameter int AddrWidth = 12,
    parameter int UserWidth = 32,
    parameter int IdWidth   = 2
);
    logic [AddrWidth-1:0] awaddr;
    logic [1:0]           awburst;
    logic [2:0]           awsize;
    logic [7:0]           awlen;
    logic [UserWidth-1:0] awuser;
    logic [IdWidth-1:0]   awid;
    logic                 awlock;
    logic                 awvalid;
    logic                 awready;

    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic [UserWidth-1:0] wuser;
    logic                 wlast;
    logic                 wvalid;
    logic                 wready;

    logic [1:0]           bresp;
    logic [IdWidth-1:0]   bid;
    logic [UserWidth-1:0] buser;
    logic                 bvalid;
    logic                 bready;

    logic [AddrWidth-1:0] araddr;
    logic [1:0]           arburst;
    logic [2:0]           arsize;
    logic [7:0]           arlen;
    logic [UserWidth-1:0] aruser;
    logic [IdWidth-1:0]   arid;
    logic                 arlock;
    logic                 arvalid;
    logic                 arready;

    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic [IdWidth-1:0]   rid;
    logic [UserWidth-1:0] ruser;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    modport master (
        output awaddr, awburst, awsize, awlen, awuser, awid, awlock, awvalid,
        input  awready,
        output wdata, wstrb, wuser, wlast, wvalid,
        input  wready,
        input  bresp, bid, buser, bvalid,
        output bready,
        output araddr, arburst, arsize, arlen, aruser, arid, arlock, arvalid,
        input  arready,
        input  rdata, rresp, rid, ruser, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awburst, awsize, awlen, awuser, awid, awlock, awvalid,
        output awready,
        input  wdata, wstrb, wuser, wlast, wvalid,
        output wready,
        output bresp, bid, buser, bvalid,
        input  bready,
        input  araddr, arburst, arsize, arlen, aruser, arid, arlock, arvalid,
        output arready,
        output rdata, rresp, rid, ruser, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_manager_bridge.sv
// -----------------------------------------------------------------------------
// axi_manager_bridge
// Single-outstanding AXI4 manager: turns a cpuif request into one single-beat
// AXI4 read or write and returns a registered ack/err pulse.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_i, req_is_wr_i      request strobe, write select
//   addr_i                  byte address (must be word aligned)
//   wr_data_i, wr_biten_i   write data, bit enables (folded to byte strobes)
//   req_stall_o             request not accepted this cycle
//   rd_ack_o/rd_err_o/rd_data_o, wr_ack_o/wr_err_o   completion pulses
//   axi                     AXI4 manager side (axi_manager_bridge_if.master)
// Optional feature: define AXI_MGR_TIMEOUT_EN to enable the response watchdog
// (TimeoutCycles) and the DRAIN state that swallows late responses.
// -----------------------------------------------------------------------------
module axi_manager_bridge #(
    parameter int          AxiAddrWidth  = 12,
    parameter int          AxiUserWidth  = 32,
    parameter int          AxiIdWidth    = 2,
    parameter int unsigned TxnId         = 0,
    parameter int          TimeoutCycles = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    req_is_wr_i,
    input  logic [AxiAddrWidth-1:0] addr_i,
    input  logic [31:0]             wr_data_i,
    input  logic [31:0]             wr_biten_i,
    output logic                    req_stall_o,
    output logic                    rd_ack_o,
    output logic                    rd_err_o,
    output logic [31:0]             rd_data_o,
    output logic                    wr_ack_o,
    output logic                    wr_err_o,
    axi_manager_bridge_if.master    axi
);
    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] WR_ADDR_DATA = 3'd1;
    localparam logic [2:0] WR_RESP      = 3'd2;
    localparam logic [2:0] RD_ADDR      = 3'd3;
    localparam logic [2:0] RD_DATA      = 3'd4;
`ifdef AXI_MGR_TIMEOUT_EN
    localparam logic [2:0] DRAIN        = 3'd5;
    localparam int         CntW         = $clog2(TimeoutCycles);
`endif
    localparam logic [AxiIdWidth-1:0] Id = AxiIdWidth'(TxnId);

    logic [2:0]              state_q, state_d;
    logic [AxiAddrWidth-1:0] addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
    logic                    rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
    logic [31:0]             rd_data_q, rd_data_d;
    logic                    bready_c, rready_c;
    logic                    rsp_err;
`ifdef AXI_MGR_TIMEOUT_EN
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    timed_out_q, timed_out_d;
    logic                    is_wr_q, is_wr_d;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        wr_ack_d  = 1'b0;
        wr_err_d  = 1'b0;
        rd_ack_d  = 1'b0;
        rd_err_d  = 1'b0;
        rd_data_d = '0;
        bready_c  = 1'b0;
        rready_c  = 1'b0;
        rsp_err   = 1'b0;
`ifdef AXI_MGR_TIMEOUT_EN
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
        is_wr_d     = is_wr_q;
`endif
        case (state_q)
            IDLE: begin
                // An ack pulsing this cycle also stalls the requester.
                if (req_i && !wr_ack_q && !rd_ack_q) begin
                    if (addr_i[1:0] != 2'b00) begin
                        wr_ack_d = req_is_wr_i;
                        wr_err_d = req_is_wr_i;
                        rd_ack_d = ~req_is_wr_i;
                        rd_err_d = ~req_is_wr_i;
                    end else begin
                        addr_d  = addr_i;
                        wdata_d = wr_data_i;
                        wstrb_d = {|wr_biten_i[31:24], |wr_biten_i[23:16],
                                   |wr_biten_i[15:8],  |wr_biten_i[7:0]};
`ifdef AXI_MGR_TIMEOUT_EN
                        is_wr_d     = req_is_wr_i;
                        timed_out_d = 1'b0;
`endif
                        if (req_is_wr_i) begin
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                            state_d   = WR_ADDR_DATA;
                        end else begin
                            arvalid_d = 1'b1;
                            state_d   = RD_ADDR;
                        end
                    end
                end
            end
            WR_ADDR_DATA: begin
                awvalid_d = awvalid_q & ~axi.awready;
                wvalid_d  = wvalid_q & ~axi.wready;
                if (!awvalid_d && !wvalid_d) begin
`ifdef AXI_MGR_TIMEOUT_EN
                    state_d = timed_out_q ? DRAIN : WR_RESP;
`else
                    state_d = WR_RESP;
`endif
                end
            end
            WR_RESP: begin
                bready_c = 1'b1;
                if (axi.bvalid) begin
                    state_d  = IDLE;
                    wr_ack_d = 1'b1;
                    wr_err_d = axi.bresp[1] | (axi.bid != Id);
                end
            end
            RD_ADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
`ifdef AXI_MGR_TIMEOUT_EN
                    state_d = timed_out_q ? DRAIN : RD_DATA;
`else
                    state_d = RD_DATA;
`endif
                end
            end
            RD_DATA: begin
                rready_c = 1'b1;
                if (axi.rvalid) begin
                    rsp_err   = axi.rresp[1] | ~axi.rlast | (axi.rid != Id);
                    state_d   = IDLE;
                    rd_ack_d  = 1'b1;
                    rd_err_d  = rsp_err;
                    rd_data_d = rsp_err ? '0 : axi.rdata;
                end
            end
`ifdef AXI_MGR_TIMEOUT_EN
            DRAIN: begin
                // Requester already got its error ack; swallow the late response.
                bready_c = is_wr_q;
                rready_c = ~is_wr_q;
                if (is_wr_q ? axi.bvalid : axi.rvalid) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
`ifdef AXI_MGR_TIMEOUT_EN
        // Counter restarts on every state change and freezes once it fired.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != IDLE && state_q != DRAIN && !timed_out_q) begin
            if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                timed_out_d = 1'b1;
                wr_ack_d    = is_wr_q;
                wr_err_d    = is_wr_q;
                rd_ack_d    = ~is_wr_q;
                rd_err_d    = ~is_wr_q;
                if (state_q == WR_RESP || state_q == RD_DATA) state_d = DRAIN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            wr_ack_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
`ifdef AXI_MGR_TIMEOUT_EN
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
            is_wr_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            wr_ack_q  <= wr_ack_d;
            wr_err_q  <= wr_err_d;
            rd_ack_q  <= rd_ack_d;
            rd_err_q  <= rd_err_d;
            rd_data_q <= rd_data_d;
`ifdef AXI_MGR_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
            is_wr_q     <= is_wr_d;
`endif
        end
    end

    assign req_stall_o = (state_q != IDLE) | wr_ack_q | rd_ack_q;
    assign wr_ack_o    = wr_ack_q;
    assign wr_err_o    = wr_err_q;
    assign rd_ack_o    = rd_ack_q;
    assign rd_err_o    = rd_err_q;
    assign rd_data_o   = rd_data_q;

    assign axi.awaddr  = addr_q;
    assign axi.awburst = 2'b01;
    assign axi.awsize  = 3'b010;
    assign axi.awlen   = 8'd0;
    assign axi.awuser  = '0;
    assign axi.awid    = Id;
    assign axi.awlock  = 1'b0;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wuser   = '0;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_c;
    assign axi.araddr  = addr_q;
    assign axi.arburst = 2'b01;
    assign axi.arsize  = 3'b010;
    assign axi.arlen   = 8'd0;
    assign axi.aruser  = '0;
    assign axi.arid    = Id;
    assign axi.arlock  = 1'b0;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_c;

    // Response user fields carry nothing this bridge consumes.
    logic unused_sig;
    assign unused_sig = ^{axi.buser, axi.ruser, 32'(TimeoutCycles)};
endmodule

// File: tb/tb_axi_manager_bridge.sv
module tb_axi_manager_bridge;
`ifdef AXI_MGR_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req, is_wr;
    logic [11:0] addr;
    logic [31:0] wdat, biten;
    logic        stall, rd_ack, rd_err, wr_ack, wr_err;
    logic [31:0] rd_data;

    axi_manager_bridge_if #(.AddrWidth(12), .UserWidth(32), .IdWidth(2)) axi ();

    axi_manager_bridge #(
        .AxiAddrWidth(12), .AxiUserWidth(32), .AxiIdWidth(2),
        .TxnId(0), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .req_is_wr_i(is_wr), .addr_i(addr),
        .wr_data_i(wdat), .wr_biten_i(biten),
        .req_stall_o(stall),
        .rd_ack_o(rd_ack), .rd_err_o(rd_err), .rd_data_o(rd_data),
        .wr_ack_o(wr_ack), .wr_err_o(wr_err),
        .axi(axi.master)
    );

    int checks = 0;
    int errors = 0;

    // Results of the last transaction
    int          r_ack_cyc, r_ack_cnt, r_wrong, r_acyc, r_wcyc, r_hs;
    logic        r_err;
    logic [31:0] r_rdo, r_wdata;
    logic [11:0] r_addr;
    logic [3:0]  r_strb;
    bit          r_stable, r_stall_ok, r_done;

    // ---------------- reference model ----------------
    function automatic int exp_ack(bit w, logic [11:0] a, int adly, int wdly, int rdly);
        if (a[1:0] != 2'b00) return 1;
        if (w) return ((adly > wdly) ? adly : wdly) + rdly + 3;
        return adly + rdly + 3;
    endfunction

    function automatic logic exp_err(bit w, logic [11:0] a, logic [1:0] resp, logic [1:0] id, logic last);
        if (a[1:0] != 2'b00) return 1'b1;
        if (w) return resp[1] | (id != 2'd0);
        return resp[1] | ~last | (id != 2'd0);
    endfunction

    function automatic logic [3:0] exp_strb(logic [31:0] be);
        logic [3:0] s;
        for (int i = 0; i < 4; i++) s[i] = (((be >> (8 * i)) & 32'hFF) != 0);
        return s;
    endfunction

    task automatic clear_fabric();
        axi.awready = 0; axi.wready = 0; axi.arready = 0;
        axi.bvalid = 0; axi.bresp = 0; axi.bid = 0; axi.buser = 0;
        axi.rvalid = 0; axi.rresp = 0; axi.rid = 0; axi.ruser = 0;
        axi.rlast = 0; axi.rdata = 0;
    endtask

    // Drives one request (cycle 0 = current negedge) and acts as the fabric.
    // Returns at the negedge of the first free cycle so calls can chain.
    task automatic run_txn(
        input bit w, input logic [11:0] a, input logic [31:0] d, input logic [31:0] be,
        input int adly, input int wdly, input int rdly,
        input logic [1:0] resp, input logic [1:0] id, input logic last, input logic [31:0] rdat);
        int  c, a_hs, w_hs, end_c;
        bit  fin, mis, a_seen, w_seen;
        bit  hist [0:255];
        r_ack_cyc = -1; r_ack_cnt = 0; r_wrong = 0; r_err = 0; r_rdo = 0;
        r_addr = 0; r_strb = 0; r_wdata = 0; r_acyc = 0; r_wcyc = 0; r_hs = -1;
        r_stable = 1; r_stall_ok = 1; r_done = 0;
        a_hs = -1; w_hs = -1; fin = 0; a_seen = 0; w_seen = 0; end_c = 0;
        mis = (a[1:0] != 2'b00);
        if (stall !== 1'b0) r_stall_ok = 0;
        req = 1; is_wr = w; addr = a; wdat = d; biten = be;
        clear_fabric();
        c = 0;
        while (!fin && c < 200) begin
            @(negedge clk);
            c++;
            req = 0; is_wr = 1'($urandom); addr = 12'($urandom); wdat = $urandom; biten = $urandom;
            hist[c] = (stall === 1'b1);
            if ((w ? wr_ack : rd_ack) === 1'b1) begin
                r_ack_cnt++;
                if (r_ack_cyc < 0) begin
                    r_ack_cyc = c; r_err = w ? wr_err : rd_err; r_rdo = rd_data;
                end
            end
            if ((w ? rd_ack : wr_ack) !== 1'b0) r_wrong++;
            if (w) begin
                if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0) r_stable = 0;
                if (axi.awvalid === 1'b1) begin
                    r_acyc++;
                    if (!a_seen) r_addr = axi.awaddr;
                    else if (axi.awaddr !== r_addr) r_stable = 0;
                    a_seen = 1;
                    if (axi.awburst !== 2'b01 || axi.awsize !== 3'b010 || axi.awlen !== 8'd0 ||
                        axi.awlock !== 1'b0 || axi.awuser !== 32'd0 || axi.awid !== 2'd0) r_stable = 0;
                end
                if (axi.wvalid === 1'b1) begin
                    r_wcyc++;
                    if (!w_seen) begin r_strb = axi.wstrb; r_wdata = axi.wdata; end
                    else if (axi.wstrb !== r_strb || axi.wdata !== r_wdata) r_stable = 0;
                    w_seen = 1;
                    if (axi.wlast !== 1'b1 || axi.wuser !== 32'd0) r_stable = 0;
                end
                axi.awready = (c >= 1 + adly);
                axi.wready  = (c >= 1 + wdly);
                if (axi.awvalid === 1'b1 && axi.awready && a_hs < 0) a_hs = c;
                if (axi.wvalid === 1'b1 && axi.wready && w_hs < 0) w_hs = c;
                if (a_hs >= 0 && w_hs >= 0 && r_hs < 0 &&
                    c >= ((a_hs > w_hs) ? a_hs : w_hs) + 1 + rdly) begin
                    axi.bvalid = 1; axi.bresp = resp; axi.bid = id; axi.buser = $urandom;
                    if (axi.bready === 1'b1) r_hs = c;
                end else begin
                    axi.bvalid = 0; axi.bresp = 2'($urandom); axi.bid = 2'($urandom);
                end
            end else begin
                if (axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0 || axi.bready !== 1'b0) r_stable = 0;
                if (axi.arvalid === 1'b1) begin
                    r_acyc++;
                    if (!a_seen) r_addr = axi.araddr;
                    else if (axi.araddr !== r_addr) r_stable = 0;
                    a_seen = 1;
                    if (axi.arburst !== 2'b01 || axi.arsize !== 3'b010 || axi.arlen !== 8'd0 ||
                        axi.arlock !== 1'b0 || axi.aruser !== 32'd0 || axi.arid !== 2'd0) r_stable = 0;
                end
                axi.arready = (c >= 1 + adly);
                if (axi.arvalid === 1'b1 && axi.arready && a_hs < 0) a_hs = c;
                if (a_hs >= 0 && r_hs < 0 && c >= a_hs + 1 + rdly) begin
                    axi.rvalid = 1; axi.rresp = resp; axi.rid = id; axi.rlast = last;
                    axi.rdata = rdat; axi.ruser = $urandom;
                    if (axi.rready === 1'b1) r_hs = c;
                end else begin
                    axi.rvalid = 0; axi.rdata = $urandom; axi.rresp = 2'($urandom);
                end
            end
            end_c = (r_ack_cyc > r_hs) ? r_ack_cyc : r_hs;
            if (r_ack_cyc >= 0 && (mis || r_hs >= 0) && c == end_c + 1) fin = 1;
        end
        r_done = fin;
        if (!fin) r_stall_ok = 0;
        else begin
            for (int k = 1; k <= end_c; k++) if (!hist[k]) r_stall_ok = 0;
            if (hist[end_c + 1]) r_stall_ok = 0;
        end
        clear_fabric();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; req = 0; is_wr = 0; addr = 0; wdat = 0; biten = 0;
        clear_fabric();
        repeat (3) @(negedge clk);
        checks++;
        if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} !== 5'b0) begin
            errors++; $display("FAIL reset_valids: got %b want 00000",
                {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready});
        end
        checks++;
        if ({stall, wr_ack, wr_err, rd_ack, rd_err} !== 5'b0 || rd_data !== 32'd0) begin
            errors++; $display("FAIL reset_outs: got %b data %h want 00000 data 0",
                {stall, wr_ack, wr_err, rd_ack, rd_err}, rd_data);
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || axi.awvalid !== 1'b0 || axi.arvalid !== 1'b0) begin
            errors++; $display("FAIL reset_release: stall %b aw %b ar %b want 0", stall, axi.awvalid, axi.arvalid);
        end
    endtask

    task automatic test_write_basic();
        run_txn(1, 12'h010, 32'hDEADBEEF, 32'h0000FFFF, 0, 0, 0, 2'b00, 2'd0, 1'b1, 32'h0);
        checks++;
        if (r_ack_cyc !== 3 || r_ack_cnt !== 1 || r_err !== 1'b0) begin
            errors++; $display("FAIL write_basic_ack: cyc %0d cnt %0d err %b want 3 1 0", r_ack_cyc, r_ack_cnt, r_err);
        end
        checks++;
        if (r_addr !== 12'h010 || r_strb !== 4'h3 || r_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL write_basic_payload: addr %h strb %h data %h want 010 3 deadbeef", r_addr, r_strb, r_wdata);
        end
        checks++;
        if (!r_stable || !r_stall_ok || r_wrong !== 0 || r_acyc !== 1 || r_wcyc !== 1) begin
            errors++; $display("FAIL write_basic_proto: stable %b stall %b wrong %0d aw %0d w %0d want 1 1 0 1 1",
                r_stable, r_stall_ok, r_wrong, r_acyc, r_wcyc);
        end
    endtask

    task automatic test_read_basic();
        run_txn(0, 12'h010, 32'h0, 32'h0, 0, 0, 0, 2'b00, 2'd0, 1'b1, 32'h12345678);
        checks++;
        if (r_ack_cyc !== 3 || r_err !== 1'b0 || r_rdo !== 32'h12345678) begin
            errors++; $display("FAIL read_basic: cyc %0d err %b data %h want 3 0 12345678", r_ack_cyc, r_err, r_rdo);
        end
        checks++;
        if (r_addr !== 12'h010 || !r_stable || !r_stall_ok || r_ack_cnt !== 1 || r_wrong !== 0) begin
            errors++; $display("FAIL read_basic_proto: addr %h stable %b stall %b cnt %0d wrong %0d",
                r_addr, r_stable, r_stall_ok, r_ack_cnt, r_wrong);
        end
    endtask

    task automatic test_aw_stall();
        run_txn(1, 12'h024, 32'hA5A5_0F0F, 32'hFF00_0001, 5, 0, 0, 2'b00, 2'd0, 1'b1, 32'h0);
        checks++;
        if (r_acyc !== 6 || r_wcyc !== 1 || !r_stable) begin
            errors++; $display("FAIL aw_stall_valids: aw %0d w %0d stable %b want 6 1 1", r_acyc, r_wcyc, r_stable);
        end
        checks++;
        if (r_ack_cnt !== 1 || r_ack_cyc !== exp_ack(1, 12'h024, 5, 0, 0) || r_strb !== 4'b1001) begin
            errors++; $display("FAIL aw_stall_ack: cnt %0d cyc %0d strb %b want 1 %0d 1001",
                r_ack_cnt, r_ack_cyc, exp_ack(1, 12'h024, 5, 0, 0), r_strb);
        end
    endtask

    task automatic test_read_errors();
        run_txn(0, 12'h030, 32'h0, 32'h0, 0, 0, 1, 2'b10, 2'd0, 1'b1, 32'hCAFEF00D);
        checks++;
        if (r_err !== 1'b1 || r_rdo !== 32'd0 || r_ack_cnt !== 1) begin
            errors++; $display("FAIL read_slverr: err %b data %h cnt %0d want 1 0 1", r_err, r_rdo, r_ack_cnt);
        end
        run_txn(0, 12'h034, 32'h0, 32'h0, 1, 0, 0, 2'b00, 2'd0, 1'b0, 32'hCAFEF00D);
        checks++;
        if (r_err !== 1'b1 || r_rdo !== 32'd0 || r_ack_cyc !== exp_ack(0, 12'h034, 1, 0, 0)) begin
            errors++; $display("FAIL read_nolast: err %b data %h cyc %0d want 1 0 %0d",
                r_err, r_rdo, r_ack_cyc, exp_ack(0, 12'h034, 1, 0, 0));
        end
    endtask

    task automatic test_misaligned();
        run_txn(0, 12'h013, 32'h0, 32'h0, 0, 0, 0, 2'b00, 2'd0, 1'b1, 32'h1);
        checks++;
        if (r_acyc !== 0 || r_ack_cyc !== 1 || r_err !== 1'b1 || !r_stable || !r_stall_ok) begin
            errors++; $display("FAIL misaligned_rd: ar %0d cyc %0d err %b stable %b stall %b want 0 1 1 1 1",
                r_acyc, r_ack_cyc, r_err, r_stable, r_stall_ok);
        end
        run_txn(1, 12'h013, 32'h1, 32'hFFFFFFFF, 0, 0, 0, 2'b00, 2'd0, 1'b1, 32'h0);
        checks++;
        if (r_acyc !== 0 || r_wcyc !== 0 || r_ack_cyc !== 1 || r_err !== 1'b1 || r_wrong !== 0) begin
            errors++; $display("FAIL misaligned_wr: aw %0d w %0d cyc %0d err %b wrong %0d want 0 0 1 1 0",
                r_acyc, r_wcyc, r_ack_cyc, r_err, r_wrong);
        end
    endtask

    task automatic test_back_to_back();
        run_txn(1, 12'h040, 32'h1111_2222, 32'hFFFF_FFFF, 0, 0, 0, 2'b00, 2'd0, 1'b1, 32'h0);
        run_txn(0, 12'h044, 32'h0, 32'h0, 0, 0, 0, 2'b00, 2'd0, 1'b1, 32'h3333_4444);
        checks++;
        if (r_ack_cyc !== 3 || r_rdo !== 32'h3333_4444 || !r_stall_ok) begin
            errors++; $display("FAIL back_to_back: cyc %0d data %h stall %b want 3 33334444 1", r_ack_cyc, r_rdo, r_stall_ok);
        end
    endtask

    task automatic test_unexpected();
        int seen = 0;
        axi.bvalid = 1; axi.rvalid = 1; axi.rlast = 1;
        repeat (3) begin
            @(negedge clk);
            if (axi.bready !== 1'b0 || axi.rready !== 1'b0 || wr_ack !== 1'b0 || rd_ack !== 1'b0) seen++;
        end
        clear_fabric();
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL unexpected_rsp: accepted in %0d cycles want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        req = 1; is_wr = 1; addr = 12'h020; wdat = 32'h5; biten = 32'hFF;
        clear_fabric();
        @(negedge clk);
        req = 0;
        checks++;
        if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1) begin
            errors++; $display("FAIL reset_mid_start: aw %b w %b want 1 1", axi.awvalid, axi.wvalid);
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks++;
        if (axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL reset_mid_drop: aw %b w %b stall %b want 0 0 0", axi.awvalid, axi.wvalid, stall);
        end
        axi.awready = 1; axi.wready = 1; axi.bvalid = 1;
        repeat (4) begin
            @(negedge clk);
            if (wr_ack !== 1'b0 || rd_ack !== 1'b0 || axi.awvalid !== 1'b0) acks++;
        end
        clear_fabric();
        checks++;
        if (acks !== 0) begin
            errors++; $display("FAIL reset_mid_lost: activity in %0d cycles want 0", acks);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            bit          w;
            logic [11:0] a;
            logic [31:0] d, be, rdat;
            logic [1:0]  resp, id;
            logic        last;
            int          adly, wdly, rdly;
            w = 1'($urandom);
            a = 12'($urandom);
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            d = $urandom; be = $urandom; rdat = $urandom;
            if ($urandom_range(0, 1) == 0) be[15:8] = 8'h00;
            resp = 2'($urandom);
            id   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            last = ($urandom_range(0, 5) != 0);
            adly = $urandom_range(0, 3); wdly = $urandom_range(0, 3); rdly = $urandom_range(0, 3);
            run_txn(w, a, d, be, adly, wdly, rdly, resp, id, last, rdat);
            checks++;
            if (!r_done || r_ack_cnt !== 1 || r_wrong !== 0 ||
                r_ack_cyc !== exp_ack(w, a, adly, wdly, rdly) || r_err !== exp_err(w, a, resp, id, last)) begin
                errors++; $display("FAIL rand_ack[%0d]: done %b cnt %0d wrong %0d cyc %0d err %b want cyc %0d err %b",
                    n, r_done, r_ack_cnt, r_wrong, r_ack_cyc, r_err,
                    exp_ack(w, a, adly, wdly, rdly), exp_err(w, a, resp, id, last));
            end
            checks++;
            if (!r_stable || !r_stall_ok) begin
                errors++; $display("FAIL rand_proto[%0d]: stable %b stall %b want 1 1", n, r_stable, r_stall_ok);
            end
            if (a[1:0] == 2'b00) begin
                checks++;
                if (r_addr !== a || r_acyc !== adly + 1) begin
                    errors++; $display("FAIL rand_addr[%0d]: addr %h cycles %0d want %h %0d", n, r_addr, r_acyc, a, adly + 1);
                end
                checks++;
                if (w && (r_strb !== exp_strb(be) || r_wdata !== d || r_wcyc !== wdly + 1)) begin
                    errors++; $display("FAIL rand_wdata[%0d]: strb %h data %h wcyc %0d want %h %h %0d",
                        n, r_strb, r_wdata, r_wcyc, exp_strb(be), d, wdly + 1);
                end else if (!w && r_rdo !== (exp_err(w, a, resp, id, last) ? 32'd0 : rdat)) begin
                    errors++; $display("FAIL rand_rdata[%0d]: data %h want %h", n, r_rdo,
                        exp_err(w, a, resp, id, last) ? 32'd0 : rdat);
                end
            end
        end
    endtask

`ifdef AXI_MGR_TIMEOUT_EN
    task automatic test_timeout();
        run_txn(1, 12'h050, 32'h77, 32'hFF, 0, 0, 20, 2'b00, 2'd0, 1'b1, 32'h0);
        checks++;
        if (r_ack_cyc !== 10 || r_err !== 1'b1 || r_ack_cnt !== 1) begin
            errors++; $display("FAIL timeout_ack: cyc %0d err %b cnt %0d want 10 1 1", r_ack_cyc, r_err, r_ack_cnt);
        end
        checks++;
        if (r_hs !== 22 || !r_stall_ok || !r_done) begin
            errors++; $display("FAIL timeout_drain: hs %0d stall %b done %b want 22 1 1", r_hs, r_stall_ok, r_done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_aw_stall();
        test_read_errors();
        test_misaligned();
        test_back_to_back();
        test_unexpected();
        test_reset_mid();
`ifdef AXI_MGR_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
